serial_add_ctrl: RTL

Bit-serial add/subtract sequencer built around a single 1-bit full-adder cell (sum = a^b^cin, cout = a&b | (a^b)&cin).
- Accepts one WIDTH-bit operand pair through a valid/ready handshake.
- Steps the full-adder cell LSB-first over WIDTH cycles, holding the carry in a flop between bits.
- Returns sum, carry-out and signed overflow through a second valid/ready handshake.
- Trades latency for area wherever a multi-bit adder in the datapath is too large.

---
 rtl/serial_add_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full-adder cell stepped LSB-first over
// WIDTH cycles, with valid/ready handshakes on both the operand and result side.

module serial_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | ((a ^ b) & cin);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_sr, b_sr, sum_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum, fa_cout;
    logic               last_bit;
    logic [WIDTH-1:0]   sum_next;

    serial_fa_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    assign last_bit  = (state_q == RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign sum_next  = {fa_sum, sum_sr[WIDTH-1:1]};
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Subtract is folded in at load time: B is inverted and the carry seeded with 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            sum_sr   <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            out_sum  <= '0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (state_q == IDLE && in_valid) begin
            a_sr  <= in_a;
            b_sr  <= in_sub ? ~in_b : in_b;
            carry <= in_sub;
            cnt   <= '0;
        end else if (state_q == RUN) begin
            sum_sr <= sum_next;
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= fa_cout;
            cnt    <= cnt + 1'b1;
            if (last_bit) begin
                out_sum  <= sum_next;
                out_cout <= fa_cout;
                // carry into the MSB differs from carry out => signed overflow
                out_ovf  <= carry ^ fa_cout;
            end
        end
    end
endmodule
